// File: rtl/sha256_uart_host.sv
// Host-side initiator for the UART SHA-256 frame protocol: sends 01 <payload> FF and collects a 32-byte digest.
// Optional reply watchdog enabled by defining SHA256_HOST_TIMEOUT_EN.

module uart_tx_core #(
  parameter int BAUD_DIV = 234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy
);
  localparam int CW = $clog2(BAUD_DIV + 1);

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shift;

  // 10-bit frame (start, 8 data LSB-first, stop); tx_busy rises the cycle after tx_start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '1;
    end else if (!tx_busy) begin
      if (tx_start) begin
        shift    <= {1'b1, tx_data, 1'b0};
        tx       <= 1'b0;
        tx_busy  <= 1'b1;
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end
    end else if (baud_cnt == CW'(BAUD_DIV - 1)) begin
      baud_cnt <= '0;
      if (bit_cnt == 4'd9) begin
        tx_busy <= 1'b0;
        tx      <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        shift   <= {1'b1, shift[9:1]};
        tx      <= shift[1];
      end
    end else begin
      baud_cnt <= baud_cnt + CW'(1);
    end
  end
endmodule

module uart_rx_core #(
  parameter int BAUD_DIV = 234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid
);
  localparam int CW = $clog2(BAUD_DIV + 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t     state;
  logic          rx_meta, rx_sync;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    data;

  // Start edge is re-checked at mid-bit, then every bit is sampled at its centre
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= R_IDLE;
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      cnt      <= '0;
      bit_idx  <= '0;
      data     <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      rx_valid <= 1'b0;
      case (state)
        R_IDLE: begin
          cnt <= '0;
          if (!rx_sync) state <= R_START;
        end
        R_START: begin
          if (cnt == CW'(BAUD_DIV / 2 - 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? R_IDLE : R_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        R_DATA: begin
          if (cnt == CW'(BAUD_DIV - 1)) begin
            cnt  <= '0;
            data <= {rx_sync, data[7:1]};
            if (bit_idx == 3'd7) state <= R_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        R_STOP: begin
          if (cnt == CW'(BAUD_DIV - 1)) begin
            cnt   <= '0;
            state <= R_IDLE;
            if (rx_sync) begin
              rx_valid <= 1'b1;
              rx_data  <= data;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end
endmodule

module sha256_uart_host #(
  parameter int CLK_FREQ       = 27_000_000,
  parameter int BAUD           = 115200,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic         uart_tx,
  input  logic         uart_rx,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy,
  output logic         early_term,
  output logic         err_timeout
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD;

  typedef enum logic [2:0] {IDLE, SEND_START, PAYLOAD, TERM, RECV, DRAIN} state_t;

  state_t       state;
  logic         tx_start, tx_pending, tx_busy, tx_free;
  logic [7:0]   tx_data;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [255:0] shreg;
  logic [4:0]   count;

`ifdef SHA256_HOST_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd;
`else
  assign err_timeout = 1'b0;
`endif

  uart_tx_core #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .tx(uart_tx), .tx_busy(tx_busy)
  );

  uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk(clk), .rst(rst), .rx(uart_rx), .rx_data(rx_data), .rx_valid(rx_valid)
  );

  // tx_pending covers the cycle before tx_busy rises, so a second byte can never slip in
  assign tx_free = !tx_busy && !tx_pending;
  assign s_ready = (state == PAYLOAD) && tx_free;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tx_start     <= 1'b0;
      tx_pending   <= 1'b0;
      tx_data      <= '0;
      shreg        <= '0;
      count        <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
      early_term   <= 1'b0;
`ifdef SHA256_HOST_TIMEOUT_EN
      wd           <= '0;
      err_timeout  <= 1'b0;
`endif
    end else begin
      tx_start     <= 1'b0;
      tx_pending   <= 1'b0;
      digest_valid <= 1'b0;
`ifdef SHA256_HOST_TIMEOUT_EN
      err_timeout  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (s_valid && tx_free) begin
            early_term <= 1'b0;
            tx_data    <= 8'h01;
            tx_start   <= 1'b1;
            tx_pending <= 1'b1;
            state      <= SEND_START;
          end
        end
        SEND_START: begin
          if (tx_free) state <= PAYLOAD;
        end
        PAYLOAD: begin
          if (s_valid && tx_free) begin
            tx_data    <= s_data;
            tx_start   <= 1'b1;
            tx_pending <= 1'b1;
            // A payload 0xFF doubles as the terminator, so the frame ends here
            if (s_data == 8'hFF) begin
              early_term <= 1'b1;
              count      <= '0;
`ifdef SHA256_HOST_TIMEOUT_EN
              wd         <= '0;
`endif
              state      <= RECV;
            end else if (s_last) begin
              state <= TERM;
            end
          end
        end
        TERM: begin
          if (tx_free) begin
            tx_data    <= 8'hFF;
            tx_start   <= 1'b1;
            tx_pending <= 1'b1;
            count      <= '0;
`ifdef SHA256_HOST_TIMEOUT_EN
            wd         <= '0;
`endif
            state      <= RECV;
          end
        end
        RECV: begin
          if (rx_valid) begin
            shreg <= {shreg[247:0], rx_data};
            count <= count + 5'd1;
`ifdef SHA256_HOST_TIMEOUT_EN
            wd    <= '0;
`endif
            if (count == 5'd31) begin
              digest       <= {shreg[247:0], rx_data};
              digest_valid <= 1'b1;
              state        <= DRAIN;
            end
          end
`ifdef SHA256_HOST_TIMEOUT_EN
          else if (wd == WW'(TIMEOUT_CYCLES)) begin
            err_timeout <= 1'b1;
            state       <= DRAIN;
          end else begin
            wd <= wd + WW'(1);
          end
`endif
        end
        DRAIN: begin
          if (tx_free) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_uart_host.sv
// Self-checking bench for sha256_uart_host with a behavioural UART responder replying base+0..base+N-1.
// Timeout scenario runs only when SHA256_HOST_TIMEOUT_EN is defined.

module tb_sha256_uart_host;
  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int TIMEOUT  = 5000;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   s_data;
  logic         s_valid, s_last;
  logic         s_ready, uart_tx;
  logic         uart_rx;
  logic [255:0] digest;
  logic         digest_valid, busy, early_term, err_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sha256_uart_host #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .uart_tx(uart_tx), .uart_rx(uart_rx), .digest(digest),
    .digest_valid(digest_valid), .busy(busy), .early_term(early_term), .err_timeout(err_timeout)
  );

  int dv_count = 0, to_count = 0, rst_events = 0;
  always @(negedge clk) begin
    if (digest_valid) dv_count++;
    if (err_timeout) to_count++;
  end
  always @(posedge rst) rst_events++;

  // Line monitor: decodes uart_tx, drops any character cut by reset
  logic [7:0] tx_log [0:255];
  int tx_n = 0, term_count = 0;
  initial begin : monitor
    logic [7:0] b;
    int ev;
    forever begin
      @(negedge uart_tx);
      ev = rst_events;
      repeat (DIV / 2) @(posedge clk);
      if (uart_tx == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(posedge clk);
          b[i] = uart_tx;
        end
        repeat (DIV) @(posedge clk);
        if (ev == rst_events && !rst && uart_tx == 1'b1 && tx_n < 256) begin
          tx_log[tx_n] = b;
          tx_n++;
          if (b == 8'hFF) term_count++;
        end
      end
    end
  end

  int         reply_len = 32;
  logic [7:0] reply_base = 8'h00;
  int         inject_count = 0;
  logic [7:0] inject_base = 8'h40;

  task automatic drive_rx_byte(input logic [7:0] b);
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
  endtask

  initial begin : responder
    int served, injected;
    served = 0;
    injected = 0;
    uart_rx = 1'b1;
    forever begin
      @(negedge clk);
      if (term_count > served) begin
        served++;
        for (int i = 0; i < reply_len; i++) drive_rx_byte(reply_base + 8'(i));
      end else if (inject_count > injected) begin
        injected++;
        for (int i = 0; i < 32; i++) drive_rx_byte(inject_base + 8'(i));
      end
    end
  end

  function automatic logic [255:0] exp_digest(input logic [7:0] base);
    logic [255:0] d;
    d = '0;
    for (int i = 0; i < 32; i++) d = {d[247:0], 8'(base + 8'(i))};
    return d;
  endfunction

  function automatic logic [39:0] line_since(input int mark, input int n);
    logic [39:0] g;
    g = '0;
    for (int k = 0; k < n; k++) g = {g[31:0], tx_log[mark + k]};
    return g;
  endfunction

  task automatic apply_payload(input logic [7:0] bytes [8], input int n);
    int c;
    for (int i = 0; i < n; i++) begin
      s_data  = bytes[i];
      s_last  = (i == n - 1);
      s_valid = 1'b1;
      c = 0;
      @(negedge clk);
      while (!s_ready && c < 5000) begin
        @(negedge clk);
        c++;
      end
      if (!s_ready) begin
        checks++;
        errors++;
        $display("[TB] FAIL payload_ready byte %0d got s_ready=0 want 1", i);
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_dv(input int dv0);
    for (int c = 0; c < 20000 && dv_count == dv0; c++) @(negedge clk);
    repeat (100) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 20000 && busy; c++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_ready got %b want 0", s_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_uart_tx got %b want 1", uart_tx); end
    checks++; if (digest !== 256'h0) begin errors++; $display("[TB] FAIL reset_digest got %h want 0", digest); end
    checks++; if (digest_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_digest_valid got %b want 0", digest_valid); end
    checks++; if (early_term !== 1'b0) begin errors++; $display("[TB] FAIL reset_early_term got %b want 0", early_term); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_timeout got %b want 0", err_timeout); end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_abc();
    int mark, dv0;
    logic [39:0] got;
    mark = tx_n; dv0 = dv_count;
    reply_base = 8'h00; reply_len = 32;
    apply_payload('{8'h61, 8'h62, 8'h63, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    wait_dv(dv0);
    got = line_since(mark, 5);
    checks++; if (tx_n - mark !== 5) begin errors++; $display("[TB] FAIL abc_line_len got %0d want 5", tx_n - mark); end
    checks++; if (got !== 40'h01616263FF) begin errors++; $display("[TB] FAIL abc_line got %h want 01616263ff", got); end
    checks++; if (digest !== 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f) begin
      errors++; $display("[TB] FAIL abc_digest got %h want 000102..1f", digest); end
    checks++; if (dv_count - dv0 !== 1) begin errors++; $display("[TB] FAIL abc_dv_pulses got %0d want 1", dv_count - dv0); end
    checks++; if (early_term !== 1'b0) begin errors++; $display("[TB] FAIL abc_early_term got %b want 0", early_term); end
    wait_idle();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abc_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_early_term();
    int mark, dv0, ready_hits, c;
    logic [39:0] got;
    logic et_seen;
    mark = tx_n; dv0 = dv_count; ready_hits = 0;
    reply_base = 8'h20;
    apply_payload('{8'h10, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
    s_data = 8'h20; s_last = 1'b1; s_valid = 1'b1;
    et_seen = 1'b0;
    for (c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (!busy) break;
      if (s_ready) ready_hits++;
      et_seen = early_term;
    end
    s_valid = 1'b0; s_last = 1'b0;
    got = line_since(mark, 3);
    checks++; if (tx_n - mark !== 3) begin errors++; $display("[TB] FAIL et_line_len got %0d want 3", tx_n - mark); end
    checks++; if (got !== 40'h000110FF) begin errors++; $display("[TB] FAIL et_line got %h want 0110ff", got[23:0]); end
    checks++; if (et_seen !== 1'b1 || early_term !== 1'b1) begin errors++; $display("[TB] FAIL et_flag got %b want 1", early_term); end
    checks++; if (ready_hits !== 0) begin errors++; $display("[TB] FAIL et_ready_after_ff got %0d cycles want 0", ready_hits); end
    checks++; if (digest !== exp_digest(8'h20)) begin errors++; $display("[TB] FAIL et_digest got %h want %h", digest, exp_digest(8'h20)); end
    checks++; if (dv_count - dv0 !== 1) begin errors++; $display("[TB] FAIL et_dv_pulses got %0d want 1", dv_count - dv0); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_single_zero();
    int mark, dv0, busy_low;
    logic [39:0] got;
    mark = tx_n; dv0 = dv_count; busy_low = 0;
    reply_base = 8'h80;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy_before got %b want 0", busy); end
    apply_payload('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL zero_busy_during got %b want 1", busy); end
    checks++; if (early_term !== 1'b0) begin errors++; $display("[TB] FAIL zero_early_term_cleared got %b want 0", early_term); end
    for (int c = 0; c < 20000 && dv_count == dv0; c++) begin
      @(negedge clk);
      if (!busy && dv_count == dv0) busy_low++;
    end
    checks++; if (busy_low !== 0) begin errors++; $display("[TB] FAIL zero_busy_gap got %0d low cycles want 0", busy_low); end
    wait_idle();
    got = line_since(mark, 3);
    checks++; if (got !== 40'h000100FF || tx_n - mark !== 3) begin errors++; $display("[TB] FAIL zero_line got %h len %0d want 0100ff len 3", got[23:0], tx_n - mark); end
    checks++; if (digest !== exp_digest(8'h80)) begin errors++; $display("[TB] FAIL zero_digest got %h want %h", digest, exp_digest(8'h80)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_idle got busy=%b want 0", busy); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_rx_outside_frame();
    int dv0;
    dv0 = dv_count;
    inject_base = 8'h40;
    inject_count++;
    repeat (32 * 12 * DIV + 300) @(negedge clk);
    checks++; if (digest !== exp_digest(8'h80)) begin errors++; $display("[TB] FAIL idle_rx_digest got %h want %h", digest, exp_digest(8'h80)); end
    checks++; if (dv_count !== dv0) begin errors++; $display("[TB] FAIL idle_rx_dv got %0d pulses want 0", dv_count - dv0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_rx_busy got %b want 0", busy); end
  endtask

`ifdef SHA256_HOST_TIMEOUT_EN
  task automatic test_timeout();
    int dv0, to0;
    dv0 = dv_count; to0 = to_count;
    reply_base = 8'h33; reply_len = 10;
    apply_payload('{8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1);
    for (int c = 0; c < 30000 && to_count == to0; c++) @(negedge clk);
    wait_idle();
    reply_len = 32;
    checks++; if (to_count - to0 !== 1) begin errors++; $display("[TB] FAIL to_pulses got %0d want 1", to_count - to0); end
    checks++; if (digest !== exp_digest(8'h80)) begin errors++; $display("[TB] FAIL to_digest got %h want %h", digest, exp_digest(8'h80)); end
    checks++; if (dv_count !== dv0) begin errors++; $display("[TB] FAIL to_dv got %0d pulses want 0", dv_count - dv0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL to_idle got busy=%b want 0", busy); end
    repeat (20) @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid_payload();
    int mark, dv0, c;
    logic [39:0] got;
    reply_base = 8'h55;
    s_data = 8'h61; s_last = 1'b0; s_valid = 1'b1;
    for (c = 0; c < 5000 && !s_ready; c++) @(negedge clk);
    @(posedge clk); #1;
    s_data = 8'h62;
    repeat (35) @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("[TB] FAIL midrst_uart_tx got %b want 1", uart_tx); end
    checks++; if (busy !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy_ready got %b%b want 00", busy, s_ready); end
    checks++; if (digest !== 256'h0) begin errors++; $display("[TB] FAIL midrst_digest got %h want 0", digest); end
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    mark = tx_n; dv0 = dv_count;
    apply_payload('{8'h61, 8'h62, 8'h63, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    wait_dv(dv0);
    got = line_since(mark, 5);
    checks++; if (got !== 40'h01616263FF || tx_n - mark !== 5) begin errors++; $display("[TB] FAIL midrst_line got %h len %0d want 01616263ff len 5", got, tx_n - mark); end
    checks++; if (digest !== exp_digest(8'h55)) begin errors++; $display("[TB] FAIL midrst_digest_after got %h want %h", digest, exp_digest(8'h55)); end
    checks++; if (dv_count - dv0 !== 1) begin errors++; $display("[TB] FAIL midrst_dv got %0d want 1", dv_count - dv0); end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_early_term();
    test_single_zero();
    test_rx_outside_frame();
`ifdef SHA256_HOST_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_payload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900_000;
    $display("[TB] FAIL global_timeout got still running want finished");
    $fatal(1, "[TB] simulation time limit");
  end
endmodule
